// File: rtl/decode_ctrl_pipe.sv
// MIPS-I main-decode stage: combinational control decode latched into the ID/EX control register,
// plus a HI/LO occupancy counter that holds back dependent HI/LO instructions.
module decode_ctrl_pipe #(
   parameter int unsigned DIV_LATENCY = 32,
   parameter int unsigned MUL_LATENCY = 2,
   parameter int unsigned CNT_W       = 6,
   parameter bit          EN_RI       = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic        ex_stall,
   input  logic        flush,
   output logic        out_valid,
   output logic [3:0]  aluop,
   output logic [1:0]  alusrc,
   output logic [1:0]  hilowrite,
   output logic        regwrite,
   output logic        regdst,
   output logic        memwrite,
   output logic        memtoreg,
   output logic        branch,
   output logic        bal,
   output logic        jump,
   output logic        jal,
   output logic        jr,
   output logic        jalr,
   output logic        ri_exc,
   output logic        hilo_busy
);

   localparam logic [3:0] ALU_R       = 4'd1;
   localparam logic [3:0] ALU_ADDI    = 4'd2;
   localparam logic [3:0] ALU_ADDIU   = 4'd3;
   localparam logic [3:0] ALU_SLTI    = 4'd4;
   localparam logic [3:0] ALU_SLTIU   = 4'd5;
   localparam logic [3:0] ALU_ANDI    = 4'd6;
   localparam logic [3:0] ALU_ORI     = 4'd7;
   localparam logic [3:0] ALU_XORI    = 4'd8;
   localparam logic [3:0] ALU_LUI     = 4'd9;
   localparam logic [3:0] ALU_MEM     = 4'd10;
   localparam logic [3:0] ALU_BRANCH  = 4'd11;
   localparam logic [3:0] ALU_USELESS = 4'd15;

   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY);

   typedef struct packed {
      logic [3:0] aluop;
      logic [1:0] alusrc;
      logic [1:0] hilowrite;
      logic       regwrite;
      logic       regdst;
      logic       memwrite;
      logic       memtoreg;
      logic       branch;
      logic       bal;
      logic       jump;
      logic       jal;
      logic       jr;
      logic       jalr;
      logic       ri_exc;
   } ctrl_t;

   ctrl_t            dec, ctrl_q;
   logic             valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic             known, is_hilo, is_div, is_mul, accept;
   logic [5:0]       op, fn;
   logic [4:0]       rt;
   logic             unused_fields;

   assign op = instr[31:26];
   assign fn = instr[5:0];
   assign rt = instr[20:16];
   assign unused_fields = ^{instr[25:21], instr[15:6]};

   always_comb begin
      dec       = '0;
      dec.aluop = ALU_USELESS;
      known     = 1'b1;
      is_hilo   = 1'b0;
      is_div    = 1'b0;
      is_mul    = 1'b0;
      case (op)
         6'h00: begin
            dec.aluop = ALU_R;
            case (fn)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                  dec.regwrite = 1'b1;
                  dec.regdst   = 1'b1;
               end
               6'h08: dec.jr = 1'b1;
               6'h09: begin
                  dec.jalr     = 1'b1;
                  dec.regwrite = 1'b1;
                  dec.regdst   = 1'b1;
               end
               6'h10, 6'h12: begin
                  dec.regwrite = 1'b1;
                  dec.regdst   = 1'b1;
                  is_hilo      = 1'b1;
               end
               6'h11: begin
                  dec.hilowrite = 2'b10;
                  is_hilo       = 1'b1;
               end
               6'h13: begin
                  dec.hilowrite = 2'b01;
                  is_hilo       = 1'b1;
               end
               6'h18, 6'h19: begin
                  dec.hilowrite = 2'b11;
                  is_hilo       = 1'b1;
                  is_mul        = 1'b1;
               end
               6'h1A, 6'h1B: begin
                  dec.hilowrite = 2'b11;
                  is_hilo       = 1'b1;
                  is_div        = 1'b1;
               end
               default: known = 1'b0;
            endcase
         end
         6'h01: begin
            dec.aluop = ALU_BRANCH;
            case (rt)
               5'h00, 5'h01: dec.branch = 1'b1;
               5'h10, 5'h11: begin
                  dec.branch   = 1'b1;
                  dec.bal      = 1'b1;
                  dec.regwrite = 1'b1;
               end
               default: known = 1'b0;
            endcase
         end
         6'h02: dec.jump = 1'b1;
         6'h03: begin
            dec.jal      = 1'b1;
            dec.regwrite = 1'b1;
         end
         6'h04, 6'h05, 6'h06, 6'h07: begin
            dec.aluop  = ALU_BRANCH;
            dec.branch = 1'b1;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B: begin
            dec.aluop    = (op == 6'h08) ? ALU_ADDI : (op == 6'h09) ? ALU_ADDIU :
                           (op == 6'h0A) ? ALU_SLTI : ALU_SLTIU;
            dec.alusrc   = 2'b01;
            dec.regwrite = 1'b1;
         end
         6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            dec.aluop    = (op == 6'h0C) ? ALU_ANDI : (op == 6'h0D) ? ALU_ORI :
                           (op == 6'h0E) ? ALU_XORI : ALU_LUI;
            dec.alusrc   = 2'b10;
            dec.regwrite = 1'b1;
         end
         6'h23: begin
            dec.aluop    = ALU_MEM;
            dec.alusrc   = 2'b01;
            dec.regwrite = 1'b1;
            dec.memtoreg = 1'b1;
         end
         6'h2B: begin
            dec.aluop    = ALU_MEM;
            dec.alusrc   = 2'b01;
            dec.memwrite = 1'b1;
         end
         default: known = 1'b0;
      endcase
      // Undecodable words become a NOP bundle, optionally tagged as a reserved instruction.
      if (!known) begin
         dec        = '0;
         dec.aluop  = ALU_USELESS;
         dec.ri_exc = EN_RI;
      end
   end

   assign hilo_busy = (cnt_q != '0);
   assign in_ready  = !ex_stall && !(is_hilo && hilo_busy) && !rst;
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (ex_stall) begin
         valid_q <= valid_q;
         ctrl_q  <= ctrl_q;
      end else if (accept) begin
         valid_q <= 1'b1;
         ctrl_q  <= dec;
      end else begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end
   end

   // The counter keeps running through stalls and flushes: an issued HI/LO op always completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept && is_div) begin
         cnt_q <= DIV_LOAD;
      end else if (accept && is_mul) begin
         cnt_q <= MUL_LOAD;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign out_valid = valid_q;
   assign aluop     = ctrl_q.aluop;
   assign alusrc    = ctrl_q.alusrc;
   assign hilowrite = ctrl_q.hilowrite;
   assign regwrite  = ctrl_q.regwrite;
   assign regdst    = ctrl_q.regdst;
   assign memwrite  = ctrl_q.memwrite;
   assign memtoreg  = ctrl_q.memtoreg;
   assign branch    = ctrl_q.branch;
   assign bal       = ctrl_q.bal;
   assign jump      = ctrl_q.jump;
   assign jal       = ctrl_q.jal;
   assign jr        = ctrl_q.jr;
   assign jalr      = ctrl_q.jalr;
   assign ri_exc    = ctrl_q.ri_exc;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: mnemonic-level reference model compared every cycle against two
// instances (EN_RI=1 and EN_RI=0), plus directed literal checks.
module tb_decode_ctrl_pipe;

   localparam logic [3:0] ALU_R = 4'd1, ALU_ADDI = 4'd2, ALU_ADDIU = 4'd3, ALU_SLTI = 4'd4;
   localparam logic [3:0] ALU_SLTIU = 4'd5, ALU_ANDI = 4'd6, ALU_ORI = 4'd7, ALU_XORI = 4'd8;
   localparam logic [3:0] ALU_LUI = 4'd9, ALU_MEM = 4'd10, ALU_BRANCH = 4'd11, ALU_USELESS = 4'd15;

   localparam logic [31:0] I_ADDI = 32'h21080005, I_ORI = 32'h35290010, I_DIV = 32'h0109001A;
   localparam logic [31:0] I_MFHI = 32'h00005010, I_LW = 32'h8D280004, I_MULT = 32'h01090018;
   localparam logic [31:0] I_BEQ = 32'h11090003, I_BAD = 32'hFC000000;

   typedef struct packed {
      logic [3:0] aluop;
      logic [1:0] alusrc;
      logic [1:0] hilowrite;
      logic regwrite, regdst, memwrite, memtoreg, branch, bal, jump, jal, jr, jalr, ri;
   } bundle_t;

   typedef enum int {
      M_ALU, M_JR, M_JALR, M_MFHI, M_MFLO, M_MTHI, M_MTLO, M_MULT, M_MULTU, M_DIV, M_DIVU,
      M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL, M_J, M_JAL, M_BEQ, M_BNE, M_BLEZ, M_BGTZ,
      M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BAD
   } mnem_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        ex_stall = 1'b0;
   logic        flush = 1'b0;

   logic in_ready_a, out_valid_a, regwrite_a, regdst_a, memwrite_a, memtoreg_a, branch_a, bal_a;
   logic jump_a, jal_a, jr_a, jalr_a, ri_a, hilo_busy_a;
   logic [3:0] aluop_a;
   logic [1:0] alusrc_a, hilowrite_a;
   logic in_ready_b, out_valid_b, regwrite_b, regdst_b, memwrite_b, memtoreg_b, branch_b, bal_b;
   logic jump_b, jal_b, jr_b, jalr_b, ri_b, hilo_busy_b;
   logic [3:0] aluop_b;
   logic [1:0] alusrc_b, hilowrite_b;
   bundle_t act_a, act_b;

   bundle_t m_a = '0, m_b = '0;
   bit      m_valid = 1'b0;
   int      m_cnt = 0;
   int      compared = 0, mismatched = 0;

   logic [5:0] op_tbl [16] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                               6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
   logic [5:0] hl_tbl [8] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};

   always #5 clk = ~clk;

   decode_ctrl_pipe #(.EN_RI(1'b1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .instr(instr),
      .ex_stall(ex_stall), .flush(flush), .out_valid(out_valid_a), .aluop(aluop_a),
      .alusrc(alusrc_a), .hilowrite(hilowrite_a), .regwrite(regwrite_a), .regdst(regdst_a),
      .memwrite(memwrite_a), .memtoreg(memtoreg_a), .branch(branch_a), .bal(bal_a),
      .jump(jump_a), .jal(jal_a), .jr(jr_a), .jalr(jalr_a), .ri_exc(ri_a),
      .hilo_busy(hilo_busy_a)
   );

   decode_ctrl_pipe #(.EN_RI(1'b0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .instr(instr),
      .ex_stall(ex_stall), .flush(flush), .out_valid(out_valid_b), .aluop(aluop_b),
      .alusrc(alusrc_b), .hilowrite(hilowrite_b), .regwrite(regwrite_b), .regdst(regdst_b),
      .memwrite(memwrite_b), .memtoreg(memtoreg_b), .branch(branch_b), .bal(bal_b),
      .jump(jump_b), .jal(jal_b), .jr(jr_b), .jalr(jalr_b), .ri_exc(ri_b),
      .hilo_busy(hilo_busy_b)
   );

   assign act_a = {aluop_a, alusrc_a, hilowrite_a, regwrite_a, regdst_a, memwrite_a, memtoreg_a,
                   branch_a, bal_a, jump_a, jal_a, jr_a, jalr_a, ri_a};
   assign act_b = {aluop_b, alusrc_b, hilowrite_b, regwrite_b, regdst_b, memwrite_b, memtoreg_b,
                   branch_b, bal_b, jump_b, jal_b, jr_b, jalr_b, ri_b};

   function automatic mnem_t classify(input logic [31:0] w);
      mnem_t m;
      m = M_BAD;
      case (w[31:26])
         6'h00: begin
            if (w[5:0] inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A,
                               6'h2B}) begin
               m = M_ALU;
            end else begin
               case (w[5:0])
                  6'h08: m = M_JR;
                  6'h09: m = M_JALR;
                  6'h10: m = M_MFHI;
                  6'h11: m = M_MTHI;
                  6'h12: m = M_MFLO;
                  6'h13: m = M_MTLO;
                  6'h18: m = M_MULT;
                  6'h19: m = M_MULTU;
                  6'h1A: m = M_DIV;
                  6'h1B: m = M_DIVU;
                  default: m = M_BAD;
               endcase
            end
         end
         6'h01: begin
            case (w[20:16])
               5'd0:  m = M_BLTZ;
               5'd1:  m = M_BGEZ;
               5'd16: m = M_BLTZAL;
               5'd17: m = M_BGEZAL;
               default: m = M_BAD;
            endcase
         end
         6'h02: m = M_J;
         6'h03: m = M_JAL;
         6'h04: m = M_BEQ;
         6'h05: m = M_BNE;
         6'h06: m = M_BLEZ;
         6'h07: m = M_BGTZ;
         6'h08: m = M_ADDI;
         6'h09: m = M_ADDIU;
         6'h0A: m = M_SLTI;
         6'h0B: m = M_SLTIU;
         6'h0C: m = M_ANDI;
         6'h0D: m = M_ORI;
         6'h0E: m = M_XORI;
         6'h0F: m = M_LUI;
         6'h23: m = M_LW;
         6'h2B: m = M_SW;
         default: m = M_BAD;
      endcase
      return m;
   endfunction

   function automatic bundle_t expect_bundle(input mnem_t m, input bit en_ri);
      bundle_t b;
      b = '0;
      case (m)
         M_ALU, M_MFHI, M_MFLO: begin b.aluop = ALU_R; b.regwrite = 1'b1; b.regdst = 1'b1; end
         M_JR:   begin b.aluop = ALU_R; b.jr = 1'b1; end
         M_JALR: begin b.aluop = ALU_R; b.jalr = 1'b1; b.regwrite = 1'b1; b.regdst = 1'b1; end
         M_MTHI: begin b.aluop = ALU_R; b.hilowrite = 2'b10; end
         M_MTLO: begin b.aluop = ALU_R; b.hilowrite = 2'b01; end
         M_MULT, M_MULTU, M_DIV, M_DIVU: begin b.aluop = ALU_R; b.hilowrite = 2'b11; end
         M_BLTZ, M_BGEZ, M_BEQ, M_BNE, M_BLEZ, M_BGTZ: begin
            b.aluop = ALU_BRANCH; b.branch = 1'b1;
         end
         M_BLTZAL, M_BGEZAL: begin
            b.aluop = ALU_BRANCH; b.branch = 1'b1; b.bal = 1'b1; b.regwrite = 1'b1;
         end
         M_J:     begin b.aluop = ALU_USELESS; b.jump = 1'b1; end
         M_JAL:   begin b.aluop = ALU_USELESS; b.jal = 1'b1; b.regwrite = 1'b1; end
         M_ADDI:  begin b.aluop = ALU_ADDI;  b.alusrc = 2'b01; b.regwrite = 1'b1; end
         M_ADDIU: begin b.aluop = ALU_ADDIU; b.alusrc = 2'b01; b.regwrite = 1'b1; end
         M_SLTI:  begin b.aluop = ALU_SLTI;  b.alusrc = 2'b01; b.regwrite = 1'b1; end
         M_SLTIU: begin b.aluop = ALU_SLTIU; b.alusrc = 2'b01; b.regwrite = 1'b1; end
         M_ANDI:  begin b.aluop = ALU_ANDI;  b.alusrc = 2'b10; b.regwrite = 1'b1; end
         M_ORI:   begin b.aluop = ALU_ORI;   b.alusrc = 2'b10; b.regwrite = 1'b1; end
         M_XORI:  begin b.aluop = ALU_XORI;  b.alusrc = 2'b10; b.regwrite = 1'b1; end
         M_LUI:   begin b.aluop = ALU_LUI;   b.alusrc = 2'b10; b.regwrite = 1'b1; end
         M_LW: begin
            b.aluop = ALU_MEM; b.alusrc = 2'b01; b.regwrite = 1'b1; b.memtoreg = 1'b1;
         end
         M_SW:    begin b.aluop = ALU_MEM; b.alusrc = 2'b01; b.memwrite = 1'b1; end
         default: begin b.aluop = ALU_USELESS; b.ri = en_ri; end
      endcase
      return b;
   endfunction

   function automatic bit is_hilo(input mnem_t m);
      return m inside {M_MFHI, M_MFLO, M_MTHI, M_MTLO, M_MULT, M_MULTU, M_DIV, M_DIVU};
   endfunction

   function automatic int hilo_lat(input mnem_t m);
      if (m inside {M_DIV, M_DIVU}) return 32;
      if (m inside {M_MULT, M_MULTU}) return 2;
      return 0;
   endfunction

   function automatic bit exp_ready();
      return !ex_stall && !(is_hilo(classify(instr)) && m_cnt != 0) && !rst;
   endfunction

   // Reference model: advances on the same events as the DUT, from the current inputs only.
   always @(posedge clk or posedge rst) begin
      mnem_t m;
      bit    acc;
      if (rst) begin
         m_valid = 1'b0; m_a = '0; m_b = '0; m_cnt = 0;
      end else begin
         m   = classify(instr);
         acc = in_valid && exp_ready();
         if (flush) begin
            m_valid = 1'b0; m_a = '0; m_b = '0;
         end else if (ex_stall) begin
            m_valid = m_valid;
         end else if (acc) begin
            m_valid = 1'b1; m_a = expect_bundle(m, 1'b1); m_b = expect_bundle(m, 1'b0);
         end else begin
            m_valid = 1'b0; m_a = '0; m_b = '0;
         end
         if (acc && hilo_lat(m) != 0) m_cnt = hilo_lat(m);
         else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      #2;
      check("in_ready_a", 32'(in_ready_a), 32'(exp_ready()));
      check("in_ready_b", 32'(in_ready_b), 32'(exp_ready()));
      check("out_valid_a", 32'(out_valid_a), 32'(m_valid));
      check("out_valid_b", 32'(out_valid_b), 32'(m_valid));
      check("bundle_a", 32'(act_a), 32'(m_a));
      check("bundle_b", 32'(act_b), 32'(m_b));
      check("hilo_busy_a", 32'(hilo_busy_a), 32'(m_cnt != 0));
      check("hilo_busy_b", 32'(hilo_busy_b), 32'(m_cnt != 0));
   end

   task automatic tick(input bit v, input logic [31:0] w, input bit st, input bit fl);
      @(negedge clk);
      in_valid = v; instr = w; ex_stall = st; flush = fl;
      #3;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 9))
         0, 1: begin w[31:26] = 6'h00; w[5:0] = hl_tbl[$urandom_range(0, 7)]; end
         2: w = w;
         3: begin
            w[31:26] = 6'h01;
            case ($urandom_range(0, 4))
               0: w[20:16] = 5'd0;
               1: w[20:16] = 5'd1;
               2: w[20:16] = 5'd16;
               3: w[20:16] = 5'd17;
               default: w[20:16] = w[20:16];
            endcase
         end
         4: w[31:26] = 6'h00;
         default: w[31:26] = op_tbl[$urandom_range(0, 15)];
      endcase
      return w;
   endfunction

   initial begin
      // Reset held with a valid instruction presented.
      repeat (3) begin
         tick(1'b1, I_ADDI, 1'b0, 1'b0);
         check("rst_in_ready", 32'(in_ready_a), 0);
         check("rst_out_valid", 32'(out_valid_a), 0);
         check("rst_bundle", 32'(act_a), 0);
         check("rst_busy", 32'(hilo_busy_a), 0);
      end
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(in_ready_a), 1);

      // ADDI then ORI back to back.
      tick(1'b1, I_ORI, 1'b0, 1'b0);
      check("addi_valid", 32'(out_valid_a), 1);
      check("addi_regwrite", 32'(regwrite_a), 1);
      check("addi_regdst", 32'(regdst_a), 0);
      check("addi_alusrc", 32'(alusrc_a), 1);
      check("addi_aluop", 32'(aluop_a), 2);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      check("ori_valid", 32'(out_valid_a), 1);
      check("ori_alusrc", 32'(alusrc_a), 2);
      check("ori_aluop", 32'(aluop_a), 7);

      // DIV, then MFHI held valid; an ADDI slips through mid-wait.
      tick(1'b1, I_DIV, 1'b0, 1'b0);
      check("div_ready", 32'(in_ready_a), 1);
      for (int k = 1; k <= 33; k++) begin
         if (k == 10) begin
            tick(1'b1, I_ADDI, 1'b0, 1'b0);
            check("addi_during_div_ready", 32'(in_ready_a), 1);
         end else begin
            tick(1'b1, I_MFHI, 1'b0, 1'b0);
            check("mfhi_wait_ready", 32'(in_ready_a), (k == 33) ? 1 : 0);
         end
         check("div_busy", 32'(hilo_busy_a), (k == 33) ? 0 : 1);
      end
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      check("mfhi_out_valid", 32'(out_valid_a), 1);
      check("mfhi_regdst", 32'(regdst_a), 1);

      // MULT then LW, then a 4-cycle stall while the counter drains.
      tick(1'b1, I_MULT, 1'b0, 1'b0);
      tick(1'b1, I_LW, 1'b0, 1'b0);
      check("lw_ready_while_busy", 32'(in_ready_a), 1);
      for (int j = 0; j < 4; j++) begin
         tick(1'b1, I_ADDI, 1'b1, 1'b0);
         check("stall_memtoreg", 32'(memtoreg_a), 1);
         check("stall_regwrite", 32'(regwrite_a), 1);
         check("stall_alusrc", 32'(alusrc_a), 1);
         check("stall_ready", 32'(in_ready_a), 0);
         check("stall_busy", 32'(hilo_busy_a), (j == 0) ? 1 : 0);
      end

      // Flush wins over stall and a valid BEQ.
      tick(1'b1, I_BEQ, 1'b0, 1'b0);
      tick(1'b1, I_BEQ, 1'b1, 1'b1);
      check("beq_branch", 32'(branch_a), 1);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      check("flush_valid", 32'(out_valid_a), 0);
      check("flush_branch", 32'(branch_a), 0);

      // Flush during a divide leaves the unit busy.
      tick(1'b1, I_DIV, 1'b0, 1'b0);
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      check("flush_div_busy0", 32'(hilo_busy_a), 1);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      check("flush_div_busy1", 32'(hilo_busy_a), 1);
      check("flush_div_valid", 32'(out_valid_a), 0);
      repeat (31) tick(1'b0, 32'h0, 1'b0, 1'b0);
      check("div_drained", 32'(hilo_busy_a), 0);

      // Reserved opcode on both instances.
      tick(1'b1, I_BAD, 1'b0, 1'b0);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      check("ri_valid_a", 32'(out_valid_a), 1);
      check("ri_exc_a", 32'(ri_a), 1);
      check("ri_aluop_a", 32'(aluop_a), 15);
      check("ri_flags_a", 32'(act_a[14:1]), 0);
      check("ri_valid_b", 32'(out_valid_b), 1);
      check("ri_exc_b", 32'(ri_b), 0);

      // Reset in the middle of a divide.
      tick(1'b1, I_DIV, 1'b0, 1'b0);
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      check("pre_rst_busy", 32'(hilo_busy_a), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(hilo_busy_a), 0);
      check("mid_rst_ready", 32'(in_ready_a), 0);
      tick(1'b1, I_MFHI, 1'b0, 1'b0);
      check("mid_rst_hold_valid", 32'(out_valid_a), 0);
      rst = 1'b0;

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         tick($urandom_range(0, 99) < 75, rand_instr(), $urandom_range(0, 99) < 15,
              $urandom_range(0, 99) < 8);
      end
      tick(1'b0, 32'h0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Registered, parametrised main-decode stage for the MIPS core.
- Decodes the 32-bit instruction into the standard control bundle, then latches it into the ID/EX control register. The latch supports valid/ready handshake, stall and flush.
- Tracks the multi-cycle HI/LO unit (MULT/MULTU/DIV/DIVU) with an occupancy counter. Stalls any later HI/LO instruction until the unit is free.
- Flags reserved/unsupported instructions.

Parameters:
- DIV_LATENCY, 32, cycles DIV/DIVU occupies the HI/LO unit after issue (≥1).
- MUL_LATENCY, 2, cycles MULT/MULTU occupies the HI/LO unit after issue (≥1).
- CNT_W, 6, occupancy counter width; must hold max(DIV_LATENCY, MUL_LATENCY).
- EN_RI, 1, 1 = raise ri_exc on undecodable instructions; 0 = decode them as NOP with ri_exc=0.

Ports:
- clk input 1 system clock
- rst input 1 asynchronous, active-high reset
- in_valid input 1 fetch presents instr
- in_ready output 1 stage accepts instr this cycle
- instr input 32 instruction word
- ex_stall input 1 EX cannot take new control; hold output register
- flush input 1 kill contents of output register (branch/exception)
- out_valid output 1 control bundle valid
- aluop output 4 ALU operation code, shared defines encoding
- alusrc output 2 00 reg, 01 sign-ext imm, 10 zero-ext imm
- hilowrite output 2 bit1 HI write, bit0 LO write
- regwrite, regdst, memwrite, memtoreg, branch, bal, jump, jal, jr, jalr output 1 each, standard control flags
- ri_exc output 1 reserved instruction in this slot
- hilo_busy output 1 HI/LO unit occupied (counter ≠ 0)

Behaviour:
- Reset (async, rst=1): out_valid=0, every control output 0, ri_exc=0, counter=0, hilo_busy=0. in_ready is combinational and equals 0 while rst is high.
- Decode (combinational, standard MIPS-I encodings):
  - R-type by funct; REGIMM by rt.
  - I-type: ADDI/ADDIU/SLTI/SLTIU use alusrc=01. ANDI/ORI/XORI/LUI use alusrc=10. LW/SW use alusrc=01 with memory flags.
  - JR: jr=1. JALR: jalr=1, regwrite=1, regdst=1. BLTZAL/BGEZAL: branch=1, bal=1, regwrite=1. JAL: jal=1, regwrite=1.
  - MTHI: hilowrite=10. MTLO: hilowrite=01. MULT*/DIV*: hilowrite=11.
  - Unknown op, or unknown rt under REGIMM: all flags 0, aluop=USELESS_OP, ri_exc=EN_RI.
- hilo_instr = MFHI|MFLO|MTHI|MTLO|MULT|MULTU|DIV|DIVU.
- Handshake:
  - in_ready = !ex_stall && !(hilo_instr && hilo_busy) && !rst.
  - accept = in_valid && in_ready.
- Output register, priority flush > ex_stall > accept > bubble:
  - flush=1: out_valid←0, all flags←0 next edge, even if ex_stall=1 or accept.
  - ex_stall=1: register holds.
  - accept: register←decoded bundle, out_valid←1.
  - Else: out_valid←0, flags←0 (bubble).
- Occupancy counter:
  - On accept of DIV/DIVU, load DIV_LATENCY. On accept of MULT/MULTU, load MUL_LATENCY.
  - Otherwise decrement if ≠0; saturate at 0.
  - Decrements regardless of ex_stall and flush. flush does not cancel an issued HI/LO op.
  - hilo_busy = (counter≠0).
- Timing and boundaries:
  - Latency instr→outputs is 1 cycle.
  - A non-HI/LO instruction is never blocked by hilo_busy.
  - MFHI after DIV is accepted on the first cycle counter reads 0, i.e. DIV_LATENCY cycles after the DIV accept edge.
  - A new MULT/DIV cannot reload a nonzero counter, because it is blocked.
  - rst asserted mid-divide clears the counter immediately.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 → in_ready=0, out_valid=0, all outputs 0; after release, first accept at next edge.
- ADDI 0x21080005 then ORI 0x35290010 back-to-back → out_valid=1 both cycles:
  - First: regwrite=1, regdst=0, alusrc=01, aluop=ADDI_OP.
  - Second: alusrc=10, aluop=ORI_OP.
- DIV 0x0109001A then MFHI 0x00005010 held valid (DIV_LATENCY=32) → hilo_busy=1 for exactly 32 cycles; in_ready=0 for MFHI for those 32 cycles; MFHI accepted on cycle 33; ADDI issued during the wait is accepted immediately.
- ex_stall=1 for 4 cycles with LW 0x8D280004 latched → outputs hold memtoreg=1, regwrite=1, alusrc=01; in_ready=0; counter still decrements.
- flush together with ex_stall and a valid BEQ → next edge out_valid=0, branch=0; flush during DIV wait leaves hilo_busy unchanged.
- Opcode 0x3F (instr 0xFC000000), EN_RI=1 → out_valid=1, ri_exc=1, all flags 0; with EN_RI=0 → ri_exc=0.
